// File: rtl/str_sampler_if.sv
// ---------------------------------------------------------------------------
// str_sampler_if
// Output stream of the self-timed-ring sampler: packed random words with a
// valid/ready handshake plus the sticky overrun flag.
//   data     packed random word, meaningful only while valid=1
//   valid    data holds an unconsumed word
//   ready    consumer takes data on a rising edge where valid=1 and ready=1
//   overrun  sticky: at least one completed word has been discarded
// master = producer (str_sampler), slave = consumer.
// ---------------------------------------------------------------------------
interface str_sampler_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] data;
    logic             valid;
    logic             ready;
    logic             overrun;

    modport master (
        output data,
        output valid,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/str_sampler.sv
// ---------------------------------------------------------------------------
// str_sampler
// Samples the stage vector of a self-timed ring, folds it to one raw bit per
// clock (XOR of all stages), optionally debiases with a von Neumann corrector
// and packs the resulting bits MSB-first into OUT_W-bit words.
//
// Ports
//   clk   sampling clock, all state updates on its rising edge
//   rst   asynchronous active-high reset
//   s     ring stage outputs (asynchronous to clk)
//   en    sampling enable, pipelined alongside s
//   bus   output stream (data / valid / ready / overrun), master side
//
// Pipeline (s sampled at edge N):
//   N   : r_sync1      N+1 : r_sync2      N+2 : r_raw_q / raw_vld
//   N+3 : r_deb_*      N+4 : packer, and data/valid when a word completes
//
// Corrector states
//   state      | meaning
//   IDLE       | no raw bit held; next valid raw bit becomes the pair's first
//   HAVE_FIRST | first bit of a pair held in r_first, waiting for the second
// ---------------------------------------------------------------------------
module str_sampler #(
    parameter int LEN   = 8,
    parameter int OUT_W = 8,
    parameter int VN_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] s,
    input  logic           en,
    str_sampler_if.master  bus
);

    localparam int CNT_W = $clog2(OUT_W);

    typedef enum logic {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } vn_state_t;

    // -----------------------------------------------------------------------
    // Synchronizer, raw bit and enable pipeline
    // -----------------------------------------------------------------------
    logic [LEN-1:0] r_sync1;
    logic [LEN-1:0] r_sync2;
    logic           r_raw_q;
    logic [2:0]     r_en_pipe;
    logic           w_raw_vld;

    // Plain two-flop synchronizer per stage bit, nothing between the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= s;
            r_sync2 <= r_sync1;
        end
    end

    // en runs through three flops so raw_vld lines up with raw_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw_q   <= 1'b0;
            r_en_pipe <= '0;
        end else begin
            r_raw_q   <= ^r_sync2;
            r_en_pipe <= {r_en_pipe[1:0], en};
        end
    end

    assign w_raw_vld = r_en_pipe[2];

    // -----------------------------------------------------------------------
    // von Neumann corrector
    // -----------------------------------------------------------------------
    vn_state_t r_state;
    vn_state_t w_state_nxt;
    logic      r_first;
    logic      w_first_nxt;
    logic      w_deb_vld;
    logic      w_deb_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_first_nxt = r_first;
        w_deb_vld   = 1'b0;
        w_deb_bit   = 1'b0;

        if (VN_EN == 0) begin
            // Bypass: every valid raw bit is a debiased bit.
            w_state_nxt = IDLE;
            w_first_nxt = 1'b0;
            w_deb_vld   = w_raw_vld;
            w_deb_bit   = r_raw_q;
        end else if (!w_raw_vld) begin
            // A gap breaks pairing; a half-collected pair is dropped.
            w_state_nxt = IDLE;
            w_first_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_first_nxt = r_raw_q;
                    w_state_nxt = HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    if (r_raw_q != r_first) begin
                        w_deb_vld = 1'b1;
                        w_deb_bit = r_first;
                    end
                    w_first_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_first_nxt = 1'b0;
                end
            endcase
        end
    end

    // Registering the corrector output keeps the s-to-bit latency at a fixed
    // three cycles regardless of VN_EN.
    logic r_deb_vld;
    logic r_deb_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_vld <= 1'b0;
            r_deb_bit <= 1'b0;
        end else begin
            r_deb_vld <= w_deb_vld;
            r_deb_bit <= w_deb_bit;
        end
    end

    // -----------------------------------------------------------------------
    // Packer and output handshake
    // -----------------------------------------------------------------------
    logic [OUT_W-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] w_word;
    logic             w_word_done;
    logic             w_load;

    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    // First bit of a word is shifted furthest and ends in the MSB.
    assign w_word      = {r_shift[OUT_W-2:0], r_deb_bit};
    assign w_word_done = r_deb_vld && (r_cnt == CNT_W'(OUT_W - 1));
    assign w_load      = w_word_done && (!r_valid || bus.ready);

    // en has no effect here: a partial word simply waits for more bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_deb_vld) begin
            if (w_word_done) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_shift <= w_word;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    // A completed word either replaces the held word (slot free or being
    // consumed this edge) or is dropped and flagged; data never changes
    // while a word is waiting on ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (w_word_done) begin
            r_overrun <= 1'b1;
        end else if (r_valid && bus.ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.data    = r_data;
    assign bus.valid   = r_valid;
    assign bus.overrun = r_overrun;

endmodule
